// File: rtl/issue_pair_queue_if.sv
// Fetch-side and decode-side signal bundle for the dual-issue instruction queue.
// The fetch/hazard logic drives through master; the queue itself uses slave.
interface issue_pair_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
);
    logic [1:0]               fetch_valid;
    logic [XLEN-1:0]          fetch_instr0;
    logic [XLEN-1:0]          fetch_pc0;
    logic [XLEN-1:0]          fetch_instr1;
    logic [XLEN-1:0]          fetch_pc1;
    logic                     fetch_ready;
    logic                     issue_stall;
    logic                     flush;
    logic [XLEN-1:0]          instr_d;
    logic [XLEN-1:0]          pc_d;
    logic                     valid_d;
    logic [XLEN-1:0]          instr_d_2;
    logic [XLEN-1:0]          pc_d_2;
    logic                     valid_d_2;
    logic                     order_change_d;
    logic [4:0]               rdd;
    logic [4:0]               rdd_2;
    logic [$clog2(DEPTH):0]   occupancy;

    modport master (
        output fetch_valid, fetch_instr0, fetch_pc0, fetch_instr1, fetch_pc1,
               issue_stall, flush,
        input  fetch_ready, instr_d, pc_d, valid_d, instr_d_2, pc_d_2, valid_d_2,
               order_change_d, rdd, rdd_2, occupancy
    );

    modport slave (
        input  fetch_valid, fetch_instr0, fetch_pc0, fetch_instr1, fetch_pc1,
               issue_stall, flush,
        output fetch_ready, instr_d, pc_d, valid_d, instr_d_2, pc_d_2, valid_d_2,
               order_change_d, rdd, rdd_2, occupancy
    );
endinterface

// File: rtl/issue_pair_queue.sv
// Dual-issue instruction buffer and IF/ID register: circular queue filled two at a
// time by fetch, drained into an ALU/mem/branch lane (DP1) and an ALU-only lane (DP2).
module issue_pair_queue #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                clk,
    input  logic                rst,
    issue_pair_queue_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];

    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] instr1_q, instr1_d, pc1_q, pc1_d;
    logic [XLEN-1:0] instr2_q, instr2_d, pc2_q, pc2_d;
    logic            valid1_q, valid1_d, valid2_q, valid2_d;
    logic            order_q, order_d;

    logic            fetch_ready, enq, two;
    logic [1:0]      enq_n, pop_n;
    logic [PW-1:0]   head_nx, tail_nx;
    logic [XLEN-1:0] ins_a, ins_b, pc_a, pc_b;
    logic            alu_a, alu_b;

    function automatic logic is_alu(input logic [6:0] op);
        return (op == 7'b0110011) || (op == 7'b0010011) ||
               (op == 7'b0110111) || (op == 7'b0010111);
    endfunction

    // Stores and branches carry no destination even though bits [11:7] are populated.
    function automatic logic [4:0] dest_of(input logic [6:0] op, input logic [4:0] rd,
                                           input logic v);
        return (v && op != 7'b0100011 && op != 7'b1100011) ? rd : 5'd0;
    endfunction

    assign head_nx     = head_q + PW'(1);
    assign tail_nx     = tail_q + PW'(1);
    assign fetch_ready = count_q <= CW'(DEPTH - 2);
    assign two         = &bus.fetch_valid;
    // bit0 gates everything, so the illegal 2'b10 pattern never enqueues.
    assign enq         = fetch_ready && bus.fetch_valid[0] && !bus.flush;
    assign enq_n       = enq ? (two ? 2'd2 : 2'd1) : 2'd0;

    assign ins_a = instr_mem[head_q];
    assign pc_a  = pc_mem[head_q];
    assign ins_b = instr_mem[head_nx];
    assign pc_b  = pc_mem[head_nx];
    assign alu_a = is_alu(ins_a[6:0]);
    assign alu_b = is_alu(ins_b[6:0]);

    always_comb begin
        instr1_d = instr1_q;
        pc1_d    = pc1_q;
        instr2_d = instr2_q;
        pc2_d    = pc2_q;
        valid1_d = valid1_q;
        valid2_d = valid2_q;
        order_d  = order_q;
        pop_n    = 2'd0;
        if (bus.flush) begin
            valid1_d = 1'b0;
            valid2_d = 1'b0;
            order_d  = 1'b0;
        end else if (!bus.issue_stall) begin
            valid1_d = 1'b0;
            valid2_d = 1'b0;
            order_d  = 1'b0;
            if (count_q == CW'(1)) begin
                instr1_d = ins_a;
                pc1_d    = pc_a;
                valid1_d = 1'b1;
                pop_n    = 2'd1;
            end else if (count_q >= CW'(2)) begin
                valid1_d = 1'b1;
                valid2_d = 1'b1;
                pop_n    = 2'd2;
                // A younger non-ALU op takes DP1 so the older ALU op can still dual-issue.
                if (alu_a && !alu_b) begin
                    instr1_d = ins_b;
                    pc1_d    = pc_b;
                    instr2_d = ins_a;
                    pc2_d    = pc_a;
                    order_d  = 1'b1;
                end else begin
                    instr1_d = ins_a;
                    pc1_d    = pc_a;
                    instr2_d = ins_b;
                    pc2_d    = pc_b;
                    if (!alu_a && !alu_b) begin
                        valid2_d = 1'b0;
                        pop_n    = 2'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        head_d  = head_q + PW'(pop_n);
        tail_d  = tail_q + PW'(enq_n);
        count_d = count_q + CW'(enq_n) - CW'(pop_n);
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            instr_mem[tail_q] <= bus.fetch_instr0;
            pc_mem[tail_q]    <= bus.fetch_pc0;
            if (two) begin
                instr_mem[tail_nx] <= bus.fetch_instr1;
                pc_mem[tail_nx]    <= bus.fetch_pc1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            instr1_q <= '0;
            pc1_q    <= '0;
            instr2_q <= '0;
            pc2_q    <= '0;
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
            order_q  <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            instr1_q <= instr1_d;
            pc1_q    <= pc1_d;
            instr2_q <= instr2_d;
            pc2_q    <= pc2_d;
            valid1_q <= valid1_d;
            valid2_q <= valid2_d;
            order_q  <= order_d;
        end
    end

    assign bus.fetch_ready    = fetch_ready;
    assign bus.instr_d        = instr1_q;
    assign bus.pc_d           = pc1_q;
    assign bus.valid_d        = valid1_q;
    assign bus.instr_d_2      = instr2_q;
    assign bus.pc_d_2         = pc2_q;
    assign bus.valid_d_2      = valid2_q;
    assign bus.order_change_d = order_q;
    assign bus.rdd            = dest_of(instr1_q[6:0], instr1_q[11:7], valid1_q);
    assign bus.rdd_2          = dest_of(instr2_q[6:0], instr2_q[11:7], valid2_q);
    assign bus.occupancy      = count_q;
endmodule

// File: tb/tb_issue_pair_queue.sv
// Randomized scoreboard bench for issue_pair_queue with a queue-based reference model
// plus directed scenarios for pairing, capacity, flush priority and async reset.
module tb_issue_pair_queue;
    localparam int DEPTH = 8;
    localparam int XLEN  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    issue_pair_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    issue_pair_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    typedef struct packed {
        logic [31:0] i1;
        logic [31:0] p1;
        logic        v2;
        logic [31:0] i2;
        logic [31:0] p2;
    } iss_t;

    typedef struct packed {
        logic [31:0] occ;
        logic        rdy;
        logic        v1;
        logic        v2;
        logic        oc;
        logic [4:0]  rd1;
        logic [4:0]  rd2;
    } cyc_t;

    ent_t mq[$];
    iss_t iq[$];
    cyc_t cq[$];

    logic        m_v1 = 1'b0, m_v2 = 1'b0, m_oc = 1'b0;
    logic [31:0] m_i1 = '0, m_i2 = '0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] pc_ctr = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit alu_op(input logic [31:0] ins);
        logic [6:0] op;
        op = ins[6:0];
        return op inside {7'h33, 7'h13, 7'h37, 7'h17};
    endfunction

    function automatic logic [4:0] dest(input logic [31:0] ins, input logic v);
        logic [6:0] op;
        op = ins[6:0];
        if (!v || op == 7'h23 || op == 7'h63) return 5'd0;
        return ins[11:7];
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [8];
        logic [31:0] r;
        ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6f};
        r = $urandom;
        r[6:0] = ops[$urandom_range(0, 7)];
        return r;
    endfunction

    // Drives one cycle of stimulus on the falling edge and advances the reference model
    // to what the queue must look like after the following rising edge.
    task automatic cycle(input logic [1:0] fv, input logic [31:0] i0, input logic [31:0] p0,
                         input logic [31:0] i1, input logic [31:0] p1,
                         input logic st, input logic fl);
        int   n;
        ent_t a, b;
        iss_t is;
        cyc_t c;
        @(negedge clk);
        bus.fetch_valid  = fv;
        bus.fetch_instr0 = i0;
        bus.fetch_pc0    = p0;
        bus.fetch_instr1 = i1;
        bus.fetch_pc1    = p1;
        bus.issue_stall  = st;
        bus.flush        = fl;
        n = mq.size();
        if (fl) begin
            mq.delete();
            m_v1 = 1'b0; m_v2 = 1'b0; m_oc = 1'b0;
        end else begin
            if (!st) begin
                m_v1 = 1'b0; m_v2 = 1'b0; m_oc = 1'b0;
                is = '0;
                if (n == 1) begin
                    a = mq.pop_front();
                    m_v1 = 1'b1; m_i1 = a.instr;
                    is.i1 = a.instr; is.p1 = a.pc;
                end else if (n >= 2) begin
                    a = mq[0];
                    b = mq[1];
                    m_v1 = 1'b1;
                    if (!alu_op(a.instr) && !alu_op(b.instr)) begin
                        void'(mq.pop_front());
                        m_i1 = a.instr;
                        is.i1 = a.instr; is.p1 = a.pc;
                    end else begin
                        void'(mq.pop_front());
                        void'(mq.pop_front());
                        m_v2 = 1'b1;
                        if (alu_op(a.instr) && !alu_op(b.instr)) begin
                            m_oc = 1'b1;
                            m_i1 = b.instr; m_i2 = a.instr;
                            is.i1 = b.instr; is.p1 = b.pc; is.i2 = a.instr; is.p2 = a.pc;
                        end else begin
                            m_i1 = a.instr; m_i2 = b.instr;
                            is.i1 = a.instr; is.p1 = a.pc; is.i2 = b.instr; is.p2 = b.pc;
                        end
                        is.v2 = 1'b1;
                    end
                end
                if (m_v1) iq.push_back(is);
            end
            if (n <= DEPTH - 2 && fv[0]) begin
                mq.push_back('{instr: i0, pc: p0});
                if (fv[1]) mq.push_back('{instr: i1, pc: p1});
            end
        end
        c.occ = mq.size();
        c.rdy = (mq.size() <= DEPTH - 2);
        c.v1  = m_v1;
        c.v2  = m_v2;
        c.oc  = m_oc;
        c.rd1 = dest(m_i1, m_v1);
        c.rd2 = dest(m_i2, m_v2);
        cq.push_back(c);
    endtask

    task automatic alu_pair(input logic st);
        logic [31:0] pa;
        pa = pc_ctr;
        pc_ctr += 8;
        cycle(2'b11, 32'h00100093, pa, 32'h00208133, pa + 4, st, 1'b0);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cycle(2'b00, '0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    // Monitor: per-edge control/status comparison, and instruction/PC comparison
    // whenever a fresh decode load shows up on an edge that was allowed to pop.
    initial begin : monitor
        logic st, fl;
        cyc_t c;
        iss_t is;
        forever begin
            @(posedge clk);
            st = bus.issue_stall;
            fl = bus.flush;
            #1;
            if (cq.size() > 0) begin
                c = cq.pop_front();
                chk("occupancy", 32'(bus.occupancy), c.occ);
                chk("fetch_ready", 32'(bus.fetch_ready), 32'(c.rdy));
                chk("valid_d", 32'(bus.valid_d), 32'(c.v1));
                chk("valid_d_2", 32'(bus.valid_d_2), 32'(c.v2));
                chk("order_change_d", 32'(bus.order_change_d), 32'(c.oc));
                chk("rdd", 32'(bus.rdd), 32'(c.rd1));
                chk("rdd_2", 32'(bus.rdd_2), 32'(c.rd2));
                if (!st && !fl && bus.valid_d) begin
                    if (iq.size() == 0) begin
                        chk("unexpected_issue", 32'(bus.valid_d), 32'd0);
                    end else begin
                        is = iq.pop_front();
                        chk("instr_d", bus.instr_d, is.i1);
                        chk("pc_d", bus.pc_d, is.p1);
                        if (is.v2) begin
                            chk("instr_d_2", bus.instr_d_2, is.i2);
                            chk("pc_d_2", bus.pc_d_2, is.p2);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        bus.fetch_valid  = 2'b00;
        bus.fetch_instr0 = '0;
        bus.fetch_pc0    = '0;
        bus.fetch_instr1 = '0;
        bus.fetch_pc1    = '0;
        bus.issue_stall  = 1'b0;
        bus.flush        = 1'b0;
        #1;
        chk("reset_occupancy", 32'(bus.occupancy), 32'd0);
        chk("reset_fetch_ready", 32'(bus.fetch_ready), 32'd1);
        chk("reset_valid_d", 32'(bus.valid_d), 32'd0);
        chk("reset_valid_d_2", 32'(bus.valid_d_2), 32'd0);
        chk("reset_rdd", 32'(bus.rdd), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ALU pair: nothing visible at the enqueue edge, paired issue one edge later
        cycle(2'b11, 32'h00100093, 32'h0, 32'h00208133, 32'h4, 1'b0, 1'b0);
        after_edge();
        chk("no_bypass_valid_d", 32'(bus.valid_d), 32'd0);
        idle(1);
        after_edge();
        chk("pair_instr_d", bus.instr_d, 32'h00100093);
        chk("pair_pc_d", bus.pc_d, 32'h0);
        chk("pair_instr_d_2", bus.instr_d_2, 32'h00208133);
        chk("pair_pc_d_2", bus.pc_d_2, 32'h4);
        chk("pair_order", 32'(bus.order_change_d), 32'd0);
        chk("pair_rdd", 32'(bus.rdd), 32'd1);
        chk("pair_rdd_2", 32'(bus.rdd_2), 32'd2);
        chk("pair_occ", 32'(bus.occupancy), 32'd0);

        // ALU then load: load steered to DP1, order flagged
        cycle(2'b11, 32'h00100093, 32'h0, 32'h0000A183, 32'h4, 1'b0, 1'b0);
        idle(1);
        after_edge();
        chk("swap_instr_d", bus.instr_d, 32'h0000A183);
        chk("swap_pc_d", bus.pc_d, 32'h4);
        chk("swap_instr_d_2", bus.instr_d_2, 32'h00100093);
        chk("swap_pc_d_2", bus.pc_d_2, 32'h0);
        chk("swap_order", 32'(bus.order_change_d), 32'd1);
        chk("swap_rdd", 32'(bus.rdd), 32'd3);
        chk("swap_rdd_2", 32'(bus.rdd_2), 32'd1);

        // Two non-ALU: single issue each
        cycle(2'b11, 32'h00112023, 32'h8, 32'h0000A183, 32'hC, 1'b0, 1'b0);
        idle(1);
        after_edge();
        chk("nonalu1_valid_d", 32'(bus.valid_d), 32'd1);
        chk("nonalu1_pc_d", bus.pc_d, 32'h8);
        chk("nonalu1_rdd", 32'(bus.rdd), 32'd0);
        chk("nonalu1_valid_d_2", 32'(bus.valid_d_2), 32'd0);
        idle(1);
        after_edge();
        chk("nonalu2_pc_d", bus.pc_d, 32'hC);
        chk("nonalu2_rdd", 32'(bus.rdd), 32'd3);
        idle(1);

        // Full: four pairs under stall fill the queue; a fifth is refused
        for (int i = 0; i < 4; i++) alu_pair(1'b1);
        after_edge();
        chk("full_occ", 32'(bus.occupancy), 32'd8);
        chk("full_ready", 32'(bus.fetch_ready), 32'd0);
        alu_pair(1'b1);
        after_edge();
        chk("full_fifth_ignored", 32'(bus.occupancy), 32'd8);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            after_edge();
            chk("drain_occ", 32'(bus.occupancy), 32'(6 - 2 * i));
        end

        // Flush wins over stall and same-cycle enqueue
        for (int i = 0; i < 3; i++) alu_pair(1'b1);
        after_edge();
        chk("preflush_occ", 32'(bus.occupancy), 32'd6);
        cycle(2'b11, 32'h00100093, 32'h100, 32'h00208133, 32'h104, 1'b1, 1'b1);
        after_edge();
        chk("flush_occ", 32'(bus.occupancy), 32'd0);
        chk("flush_valid_d", 32'(bus.valid_d), 32'd0);
        chk("flush_valid_d_2", 32'(bus.valid_d_2), 32'd0);
        idle(2);

        // Illegal 2'b10 never enqueues
        cycle(2'b10, 32'h00100093, 32'h200, 32'h00208133, 32'h204, 1'b1, 1'b0);
        after_edge();
        chk("illegal_fv_occ", 32'(bus.occupancy), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic [1:0]  fv;
            logic [31:0] pa;
            int          r;
            r = $urandom_range(0, 9);
            fv = (r < 6) ? 2'b11 : (r < 8) ? 2'b01 : (r < 9) ? 2'b00 : 2'b10;
            pa = pc_ctr;
            pc_ctr += 8;
            cycle(fv, rand_instr(), pa, rand_instr(), pa + 4,
                  ($urandom_range(0, 9) < 3), ($urandom_range(0, 39) == 0));
        end

        // Async reset mid-run with five entries held
        cycle(2'b11, rand_instr(), 32'h300, rand_instr(), 32'h304, 1'b1, 1'b1);
        cycle(2'b11, 32'h00100093, 32'h400, 32'h00208133, 32'h404, 1'b1, 1'b0);
        cycle(2'b11, 32'h00100093, 32'h408, 32'h00208133, 32'h40C, 1'b1, 1'b0);
        cycle(2'b01, 32'h00100093, 32'h410, 32'h0, 32'h0, 1'b1, 1'b0);
        after_edge();
        chk("prereset_occ", 32'(bus.occupancy), 32'd5);
        @(negedge clk);
        bus.fetch_valid = 2'b00;
        bus.issue_stall = 1'b1;
        bus.flush       = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_occ", 32'(bus.occupancy), 32'd0);
        chk("async_reset_valid_d", 32'(bus.valid_d), 32'd0);
        chk("async_reset_valid_d_2", 32'(bus.valid_d_2), 32'd0);
        chk("async_reset_ready", 32'(bus.fetch_ready), 32'd1);
        #1;
        rst = 1'b0;
        mq.delete();
        iq.delete();
        m_v1 = 1'b0; m_v2 = 1'b0; m_oc = 1'b0;
        m_i1 = '0;   m_i2 = '0;

        for (int i = 0; i < 40; i++) begin
            logic [31:0] pa;
            pa = pc_ctr;
            pc_ctr += 8;
            cycle(2'b11, rand_instr(), pa, rand_instr(), pa + 4, ($urandom_range(0, 3) == 0), 1'b0);
        end
        idle(10);
        after_edge();
        chk("scoreboard_issue_left", 32'(iq.size()), 32'd0);
        chk("scoreboard_cycle_left", 32'(cq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
